// File: rtl/round_robin_router_if.sv
// ----------------------------------------------------------------------------
// round_robin_router_if
//   Bundles the router's ingress/egress FIFO-bank signals.
//
//   Parameters
//     N       channel count (power of 2, 2..16)
//     DATA_W  word width
//
//   Signals
//     empty        per-input-FIFO empty flag, bit i = FIFO i
//     almost_full  per-output-FIFO almost-full flag
//     data_in      input FIFO read data, slice i = [i*DATA_W +: DATA_W]
//     pop          one-hot-or-zero read strobe to the input FIFOs
//     push         one-hot-or-zero write strobe to the output FIFOs
//     data_out     write data to the output FIFOs, slice d valid with push[d]
//     grant_idx    index of the last granted channel
//     idle         no input data pending and nothing in flight
//     prio_mode    fixed-priority select (only with RR_FIXED_PRIO_EN)
//
//   Modports
//     slave   router side
//     master  FIFO-bank / environment side
//
//   Build option: `define RR_FIXED_PRIO_EN adds the prio_mode signal.
// ----------------------------------------------------------------------------
interface round_robin_router_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 10
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]        empty;
  logic [N-1:0]        almost_full;
  logic [N*DATA_W-1:0] data_in;
  logic [N-1:0]        pop;
  logic [N-1:0]        push;
  logic [N*DATA_W-1:0] data_out;
  logic [IDX_W-1:0]    grant_idx;
  logic                idle;

`ifdef RR_FIXED_PRIO_EN
  logic                prio_mode;

  modport slave (
    input  empty, almost_full, data_in, prio_mode,
    output pop, push, data_out, grant_idx, idle
  );

  modport master (
    output empty, almost_full, data_in, prio_mode,
    input  pop, push, data_out, grant_idx, idle
  );
`else
  modport slave (
    input  empty, almost_full, data_in,
    output pop, push, data_out, grant_idx, idle
  );

  modport master (
    output empty, almost_full, data_in,
    input  pop, push, data_out, grant_idx, idle
  );
`endif

endinterface

// File: rtl/round_robin_router.sv
// ----------------------------------------------------------------------------
// round_robin_router
//   Arbitrates N input FIFOs with a rotating-priority round robin, pops one
//   word per grant and routes it to the output FIFO named by the destination
//   field inside the word. Any egress almost-full flag stalls new grants;
//   words already in flight (at most two) still complete.
//
//   Pipeline, cycle k = cycle where pop[g] is high:
//     k+1  input FIFO presents the word on data_in slice g (stage 1)
//     k+2  push[d] high, data_out slice d = word, d = word[DEST_LSB +: DEST_W]
//
//   Parameters
//     N         channel count, power of 2, 2..16
//     DATA_W    word width
//     DEST_LSB  LSB of the destination field (width log2(N))
//
//   Ports
//     i_clk    clock, rising edge
//     i_reset  synchronous active-high reset
//     io_bus   round_robin_router_if.slave (empty, almost_full, data_in,
//              pop, push, data_out, grant_idx, idle [, prio_mode])
//
//   Build option: `define RR_FIXED_PRIO_EN adds prio_mode; when high the
//   search always starts at channel 0 and the rotating pointer is frozen.
// ----------------------------------------------------------------------------
module round_robin_router #(
  parameter int unsigned N        = 4,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned DEST_LSB = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  round_robin_router_if.slave io_bus
);

  localparam int unsigned DEST_W = $clog2(N);

  // Elaboration-time parameter sanity checks.
  if ((N < 2) || (N > 16) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("round_robin_router: N must be a power of 2 in 2..16");
  end
  if (DEST_LSB + DEST_W > DATA_W) begin : g_bad_dest
    $error("round_robin_router: destination field exceeds DATA_W");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0]        r_pop;
  logic [N-1:0]        r_push;
  logic [N*DATA_W-1:0] r_data_out;
  logic [DEST_W-1:0]   r_grant_idx;
  logic [DEST_W-1:0]   r_ptr;
  logic                r_s1_valid;
  logic [DEST_W-1:0]   r_s1_ch;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                w_stall;
  logic                w_fixed;
  logic [N-1:0]        w_elig;
  logic [DEST_W-1:0]   w_base;
  logic [DEST_W-1:0]   w_idx;
  logic                w_found;
  logic [DEST_W-1:0]   w_g;
  logic                w_grant;
  logic [N-1:0]        w_pop_d;
  logic [DATA_W-1:0]   w_word;
  logic [DEST_W-1:0]   w_dest;
  logic [N-1:0]        w_push_d;
  logic [N*DATA_W-1:0] w_data_out_d;

  assign w_stall = |io_bus.almost_full;

`ifdef RR_FIXED_PRIO_EN
  assign w_fixed = io_bus.prio_mode;
`else
  assign w_fixed = 1'b0;
`endif

  // A channel popped this cycle still shows its pre-pop empty flag, so it is
  // excluded to avoid a second pop of a FIFO that may have held one entry.
  assign w_elig = ~io_bus.empty & ~r_pop;

  assign w_base = w_fixed ? '0 : r_ptr;

  // Rotating search from w_base upward; index arithmetic wraps because N is
  // a power of two.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = w_base + DEST_W'(off);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end
  end

  assign w_grant = w_found & ~w_stall;

  always_comb begin
    w_pop_d = '0;
    if (w_grant) begin
      w_pop_d[w_g] = 1'b1;
    end
  end

  // Stage 1: select the word returned by the FIFO popped last cycle.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_s1_ch == DEST_W'(i)) begin
        w_word = io_bus.data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_dest = w_word[DEST_LSB +: DEST_W];

  always_comb begin
    w_push_d     = '0;
    w_data_out_d = r_data_out;
    if (r_s1_valid) begin
      w_push_d[w_dest] = 1'b1;
    end
    // Only the addressed slice is updated; the others hold.
    for (int unsigned d = 0; d < N; d++) begin
      if (w_push_d[d]) begin
        w_data_out_d[d*DATA_W +: DATA_W] = w_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pop       <= '0;
      r_push      <= '0;
      r_data_out  <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_ch     <= '0;
    end else begin
      r_pop      <= w_pop_d;
      r_push     <= w_push_d;
      r_data_out <= w_data_out_d;
      if (w_grant) begin
        r_grant_idx <= w_g;
      end
      if (w_grant && !w_fixed) begin
        r_ptr <= w_g + DEST_W'(1);
      end
      // r_grant_idx names the channel whose pop is high this cycle.
      r_s1_valid <= |r_pop;
      if (|r_pop) begin
        r_s1_ch <= r_grant_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io_bus.pop       = r_pop;
  assign io_bus.push      = r_push;
  assign io_bus.data_out  = r_data_out;
  assign io_bus.grant_idx = r_grant_idx;
  assign io_bus.idle      = (&io_bus.empty) & ~(|r_pop) & ~r_s1_valid & ~(|r_push);

endmodule
